// File: rtl/counter_check_pkg.sv
// Shared types for the counter sequence checker: FSM state encoding and
// the err_kind codes reported alongside err_pulse.
package counter_check_pkg;

  typedef enum logic [1:0] {
    CHK_UNSYNC  = 2'd0,
    CHK_ACQUIRE = 2'd1,
    CHK_LOCKED  = 2'd2
  } chk_state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SEQ  = 2'd1;
  localparam logic [1:0] ERR_OVF  = 2'd2;
  localparam logic [1:0] ERR_BOTH = 2'd3;

endpackage

// File: rtl/counter_checker_sat_counter.sv
// Saturating up-counter used for the checker's running totals. Holds at
// all-ones rather than wrapping so a flood of events never reads as few.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up on inc, stop at all-ones; clr wins over inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Passive observer for a free-running wrap-around counter. Locks onto the
// count/overflow stream after LOCK_COUNT consecutive good increments, then
// reports sequence breaks and wrong overflow flags as one-cycle strobes and
// keeps saturating totals of errors and correct wraps.
module counter_checker
  import counter_check_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_count,
  input  logic             in_overflow,
  output logic             locked,
  output logic             err_pulse,
  output logic [1:0]       err_kind,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  chk_state_t       state, state_next;
  logic [WIDTH-1:0] prev, prev_next;
  logic [3:0]       good_run, good_run_next, good_run_inc;
  logic [WIDTH-1:0] exp_count;
  logic             exp_ovf, seq_ok, ovf_ok;
  logic             err_hit, wrap_hit;
  logic [1:0]       kind_next;

  assign exp_count    = prev + 1'b1;
  assign exp_ovf      = (prev == {WIDTH{1'b1}});
  assign seq_ok       = (in_count == exp_count);
  assign ovf_ok       = (in_overflow == exp_ovf);
  assign good_run_inc = good_run + 4'd1;

  // State register together with the tracked previous count and run length.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= CHK_UNSYNC;
      prev     <= '0;
      good_run <= '0;
    end else begin
      state    <= state_next;
      prev     <= prev_next;
      good_run <= good_run_next;
    end
  end

  // Next-state logic: clear drops any sample arriving with it.
  always_comb begin
    state_next    = state;
    prev_next     = prev;
    good_run_next = good_run;
    if (clear) begin
      state_next = CHK_UNSYNC;
    end else if (in_valid) begin
      prev_next = in_count;
      case (state)
        CHK_UNSYNC: begin
          good_run_next = '0;
          state_next    = CHK_ACQUIRE;
        end
        CHK_ACQUIRE: begin
          if (seq_ok) begin
            good_run_next = good_run_inc;
            if (good_run_inc == LOCK_RUN) state_next = CHK_LOCKED;
          end else begin
            good_run_next = '0;
          end
        end
        CHK_LOCKED: begin
          if (!seq_ok) begin
            good_run_next = '0;
            state_next    = CHK_ACQUIRE;
          end
        end
        default: state_next = CHK_UNSYNC;
      endcase
    end
  end

  // Error and wrap classification; only samples seen while LOCKED are judged.
  always_comb begin
    err_hit   = 1'b0;
    wrap_hit  = 1'b0;
    kind_next = ERR_NONE;
    if (!clear && in_valid && (state == CHK_LOCKED)) begin
      if (!seq_ok) begin
        err_hit   = 1'b1;
        kind_next = ovf_ok ? ERR_SEQ : ERR_BOTH;
      end else if (!ovf_ok) begin
        err_hit   = 1'b1;
        kind_next = ERR_OVF;
      end else begin
        wrap_hit = exp_ovf;
      end
    end
  end

  // Registered status outputs, aligned with the saturating totals below.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_kind  <= ERR_NONE;
    end else begin
      locked    <= (state_next == CHK_LOCKED);
      err_pulse <= err_hit;
      err_kind  <= kind_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (clk),
    .reset (reset),
    .inc   (err_hit),
    .clr   (clear),
    .q     (err_count)
  );

  sat_counter #(.W(CNT_W)) u_wrap_count (
    .clk   (clk),
    .reset (reset),
    .inc   (wrap_hit),
    .clr   (clear),
    .q     (wrap_count)
  );

endmodule

// File: tb/tb_counter_checker.sv
// Directed bench for counter_checker. Two instances share one stimulus
// stream: u_dut with 8-bit totals and u_sat with 2-bit totals so that
// saturation can be observed alongside the exact error count.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       in_valid;
  logic [3:0] in_count;
  logic       in_overflow;

  logic       locked, err_pulse;
  logic [1:0] err_kind;
  logic [7:0] err_count, wrap_count;

  logic       s_locked, s_err_pulse;
  logic [1:0] s_err_kind;
  logic [1:0] s_err_count, s_wrap_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(4), .LOCK_COUNT(2), .CNT_W(8)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_count    (in_count),
    .in_overflow (in_overflow),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_kind    (err_kind),
    .err_count   (err_count),
    .wrap_count  (wrap_count)
  );

  counter_checker #(.WIDTH(4), .LOCK_COUNT(2), .CNT_W(2)) u_sat (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .in_valid    (in_valid),
    .in_count    (in_count),
    .in_overflow (in_overflow),
    .locked      (s_locked),
    .err_pulse   (s_err_pulse),
    .err_kind    (s_err_kind),
    .err_count   (s_err_count),
    .wrap_count  (s_wrap_count)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int lk, input int ep,
                            input int ek, input int ec, input int wc);
    check({tag, ".locked"},     locked,     lk);
    check({tag, ".err_pulse"},  err_pulse,  ep);
    check({tag, ".err_kind"},   err_kind,   ek);
    check({tag, ".err_count"},  err_count,  ec);
    check({tag, ".wrap_count"}, wrap_count, wc);
  endtask

  // Apply one sample for one clock; outputs are sampled 1 ns after the edge.
  task automatic put(input logic v, input logic [3:0] c, input logic o);
    in_valid    = v;
    in_count    = c;
    in_overflow = o;
    @(posedge clk);
    #1;
    $display("t=%0t clr=%0b valid=%0b count=%0d ovf=%0b -> locked=%0b pulse=%0b kind=%0d errs=%0d wraps=%0d",
             $time, clear, v, c, o, locked, err_pulse, err_kind, err_count, wrap_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] v;
    logic [3:0] base;

    reset = 1'b1; clear = 1'b0;
    in_valid = 1'b0; in_count = '0; in_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 0, 0, 0, 0, 0);
    check("reset.sat_err_count", s_err_count, 0);
    #2 reset = 1'b0;

    // Clean stream 0..15,0,1 with overflow only on the wrap.
    for (int i = 0; i < 18; i++) begin
      v = 4'(i);
      put(1'b1, v, i == 16);
      check("clean.err_pulse", err_pulse, 0);
      if (i == 1)  check("clean.locked_s1", locked, 0);
      if (i == 2)  check("clean.locked_s2", locked, 1);
      if (i == 15) check("clean.wrap_pre", wrap_count, 0);
      if (i == 16) check("clean.wrap_post", wrap_count, 1);
    end
    check("clean.err_count", err_count, 0);

    // Skip while LOCKED: ...,5,6,8 then relock on 9,10.
    for (int c = 2; c <= 6; c++) begin
      v = 4'(c);
      put(1'b1, v, 1'b0);
    end
    put(1'b1, 4'd8, 1'b0);
    expect_out("skip", 0, 1, 1, 1, 1);
    put(1'b1, 4'd9, 1'b0);
    expect_out("skip9", 0, 0, 0, 1, 1);
    put(1'b1, 4'd10, 1'b0);
    expect_out("skip10", 1, 0, 0, 1, 1);

    // Overflow faults: missing flag on the wrap, spurious flag mid-count.
    for (int c = 11; c <= 15; c++) begin
      v = 4'(c);
      put(1'b1, v, 1'b0);
    end
    put(1'b1, 4'd0, 1'b0);
    expect_out("ovf_missing", 1, 1, 2, 2, 1);
    put(1'b1, 4'd1, 1'b0);
    check("ovf_after.err_pulse", err_pulse, 0);
    put(1'b1, 4'd2, 1'b0);
    put(1'b1, 4'd3, 1'b0);
    put(1'b1, 4'd4, 1'b1);
    expect_out("ovf_spurious", 1, 1, 2, 3, 1);
    put(1'b1, 4'd5, 1'b0);
    expect_out("ovf_clean5", 1, 0, 0, 3, 1);
    put(1'b1, 4'd6, 1'b1);
    expect_out("ovf_b2b_a", 1, 1, 2, 4, 1);
    put(1'b1, 4'd7, 1'b1);
    expect_out("ovf_b2b_b", 1, 1, 2, 5, 1);
    put(1'b1, 4'd8, 1'b0);
    expect_out("ovf_clean8", 1, 0, 0, 5, 1);

    // Both faults: 14 then 0 with overflow high.
    for (int c = 9; c <= 14; c++) begin
      v = 4'(c);
      put(1'b1, v, 1'b0);
    end
    put(1'b1, 4'd0, 1'b1);
    expect_out("both", 0, 1, 3, 6, 1);
    check("both.sat_err_count", s_err_count, 3);

    // Gaps: valid pattern 1,0,0,1 relocks normally.
    put(1'b1, 4'd1, 1'b0);
    expect_out("gap_s1", 0, 0, 0, 6, 1);
    put(1'b0, 4'd9, 1'b1);
    expect_out("gap_idle1", 0, 0, 0, 6, 1);
    put(1'b0, 4'd13, 1'b0);
    expect_out("gap_idle2", 0, 0, 0, 6, 1);
    put(1'b1, 4'd2, 1'b0);
    expect_out("gap_s2", 1, 0, 0, 6, 1);

    // clear with a bad valid sample: sample dropped, totals zeroed.
    clear = 1'b1;
    put(1'b1, 4'd9, 1'b0);
    clear = 1'b0;
    expect_out("clear", 0, 0, 0, 0, 0);
    check("clear.sat_err_count", s_err_count, 0);

    // Saturation: five SEQ errors with a relock before each.
    put(1'b1, 4'd0, 1'b0);
    base = 4'd0;
    for (int k = 0; k < 5; k++) begin
      put(1'b1, base + 4'd1, 1'b0);
      put(1'b1, base + 4'd2, 1'b0);
      check("sat.relock", locked, 1);
      put(1'b1, base + 4'd4, 1'b0);
      check("sat.err_pulse", err_pulse, 1);
      check("sat.err_kind", err_kind, 1);
      check("sat.err_count", err_count, k + 1);
      check("sat.sat_err_count", s_err_count, (k + 1 > 3) ? 3 : k + 1);
      check("sat.locked", locked, 0);
      base = base + 4'd4;
    end

    // Mid-stream reset while locked with an error pulse showing.
    put(1'b1, 4'd5, 1'b0);
    put(1'b1, 4'd6, 1'b0);
    put(1'b1, 4'd7, 1'b1);
    expect_out("pre_reset", 1, 1, 2, 6, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0, 0, 0);
    check("async_reset.sat_err_count", s_err_count, 0);
    check("async_reset.sat_locked", s_locked, 0);
    #2 reset = 1'b0;

    // After reset: 7 then 9 is UNSYNC then ACQUIRE, never an error.
    put(1'b1, 4'd7, 1'b0);
    expect_out("post_reset7", 0, 0, 0, 0, 0);
    put(1'b1, 4'd9, 1'b0);
    expect_out("post_reset9", 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
